// File: rtl/csa_sum_pipe_if.sv
// Operand/result bus for csa_sum_pipe: valid/ready operand beats in,
// valid/ready results out.
interface csa_sum_pipe_if #(
    parameter int WIDTH = 4,
    parameter int N_IN  = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N_IN*WIDTH-1:0] in_data;
    logic                  in_mode;
    logic                  in_clear;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_sum;
    logic                  out_ovf;

    // Producer/consumer side: drives operands and out_ready.
    modport master (
        output in_valid, in_data, in_mode, in_clear, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    // Adder side: accepts operands and presents results.
    modport slave (
        input  in_valid, in_data, in_mode, in_clear, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/csa_sum_pipe.sv
// Two-stage pipelined N_IN-operand adder.
// Stage 1 reduces the operands to a carry-save pair.
// Stage 2 does the final carry-propagate add, optionally adding the running
// accumulator, and flags overflow.
module csa_sum_pipe #(
    parameter int WIDTH = 4,
    parameter int N_IN  = 3
) (
    input  logic           clk,
    input  logic           rst,
    csa_sum_pipe_if.slave  bus
);
    // Carry-save vectors are wide enough to hold the full operand sum.
    // The final sum also has room for the accumulator addend.
    localparam int EW = WIDTH + $clog2(N_IN);
    localparam int XW = WIDTH + $clog2(N_IN + 1);

    logic [EW-1:0]    w_s;
    logic [EW-1:0]    w_c;
    logic [EW-1:0]    w_op;
    logic [EW-1:0]    w_t;
    logic [WIDTH-1:0] w_addend;
    logic [XW-1:0]    w_exact;
    logic             w_ovf;
    logic             w_stall;

    logic             r_s1Valid;
    logic [EW-1:0]    r_s;
    logic [EW-1:0]    r_c;
    logic             r_mode;
    logic             r_clear;
    logic             r_outValid;
    logic [WIDTH-1:0] r_outSum;
    logic             r_outOvf;
    logic [WIDTH-1:0] r_acc;

    // The pipeline freezes only while a result is waiting for the consumer.
    assign w_stall      = r_outValid & ~bus.out_ready;
    assign bus.in_ready = ~w_stall;

    // 3:2 compressor chain: each step folds one more operand into (sum, carry).
    // sum + 2*majority equals the three inputs exactly, so the shifted-out
    // carry bit is always zero at width EW and nothing is lost.
    always_comb begin
        w_op = '0;
        w_t  = '0;
        w_s  = EW'(bus.in_data[0 +: WIDTH]);
        w_c  = EW'(bus.in_data[WIDTH +: WIDTH]);
        for (int k = 2; k < N_IN; k++) begin
            w_op = EW'(bus.in_data[k*WIDTH +: WIDTH]);
            w_t  = w_s ^ w_c ^ w_op;
            w_c  = ((w_s & w_c) | (w_s & w_op) | (w_c & w_op)) << 1;
            w_s  = w_t;
        end
    end

    // Stage 1 register: captures the carry-save pair and the beat's control bits.
    // An idle input cycle becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s       <= '0;
            r_c       <= '0;
            r_mode    <= 1'b0;
            r_clear   <= 1'b0;
        end else if (!w_stall) begin
            r_s1Valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s     <= w_s;
                r_c     <= w_c;
                r_mode  <= bus.in_mode;
                r_clear <= bus.in_clear;
            end
        end
    end

    // Final add.
    // The accumulator is written on the same edge that loads a mode=1 result,
    // so r_acc already holds the previous result when the next beat reaches
    // this adder. That provides the forwarding without a bypass mux.
    always_comb begin
        w_addend = (r_mode && !r_clear) ? r_acc : '0;
        w_exact  = XW'(r_s) + XW'(r_c) + XW'(w_addend);
        w_ovf    = |w_exact[XW-1:WIDTH];
    end

    // Stage 2 / output register and running accumulator.
    // Mode=0 results never touch the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outSum   <= '0;
            r_outOvf   <= 1'b0;
            r_acc      <= '0;
        end else if (!w_stall) begin
            r_outValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_outSum <= w_exact[WIDTH-1:0];
                r_outOvf <= w_ovf;
                if (r_mode) begin
                    r_acc <= w_exact[WIDTH-1:0];
                end
            end
        end
    end

    assign bus.out_valid = r_outValid;
    assign bus.out_sum   = r_outSum;
    assign bus.out_ovf   = r_outOvf;
endmodule

// File: tb/tb_csa_sum_pipe.sv
// Testbench for csa_sum_pipe.
// It runs directed beats on a WIDTH=4/N_IN=3 instance, a random stream
// against a behavioural sum model, and two beats on a WIDTH=8/N_IN=8 instance.
module tb_csa_sum_pipe;
    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;

    logic [4:0] expQ[$];
    string      tagQ[$];
    logic [3:0] modelAcc;

    csa_sum_pipe_if #(.WIDTH(4), .N_IN(3)) bus ();
    csa_sum_pipe_if #(.WIDTH(8), .N_IN(8)) bus8 ();

    csa_sum_pipe #(.WIDTH(4), .N_IN(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    csa_sum_pipe #(.WIDTH(8), .N_IN(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    // Free-running clock; rising edges fall on 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts each comparison and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Result monitor: every handshaken result is compared with the next
    // expectation, given as {ovf, sum}.
    // A result that arrives with nothing expected is an error.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedResult", 32'(bus.out_valid), 32'd0);
                end else begin
                    checkOutput(tagQ.pop_front(), {27'd0, bus.out_ovf, bus.out_sum},
                                {27'd0, expQ.pop_front()});
                end
            end
        end
    end

    // Presents one beat and holds it until it is accepted.
    // The expectation is queued only when track is set.
    // Call at posedge+1; the task returns at posedge+1 after the accept.
    task automatic applyStimulus(input logic [11:0] data, input logic mode,
                                 input logic clear, input logic track,
                                 input logic [4:0] expVal, input string tag);
        bit accepted;
        accepted     = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_mode  = mode;
        bus.in_clear = clear;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (accepted) begin
            if (track) begin
                expQ.push_back(expVal);
                tagQ.push_back(tag);
            end
        end else begin
            checkOutput({tag, "_accept"}, 32'(bus.in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Waits a bounded time for every expected result to appear.
    task automatic drain(input string tag);
        for (int n = 0; n < 100; n++) begin
            if (expQ.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checkOutput({tag, "_drain"}, 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] data8;
        logic [11:0] rdata;
        logic        rmode;
        logic        rclear;
        logic        pending;
        int          sent;
        int          exact;

        checkCount     = 0;
        errorCount     = 0;
        modelAcc       = 4'd0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_mode    = 1'b0;
        bus.in_clear   = 1'b0;
        bus.out_ready  = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.in_data   = '0;
        bus8.in_mode   = 1'b0;
        bus8.in_clear  = 1'b0;
        bus8.out_ready = 1'b1;

        #2;
        checkOutput("rst_outValid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_outSum", 32'(bus.out_sum), 32'd0);
        checkOutput("rst_outOvf", 32'(bus.out_ovf), 32'd0);
        #10;
        rst = 1'b0;
        checkOutput("rst_inReady", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Plain sums: 5+6+7=18 wraps to 2 with overflow; 1+2+3=6.
        applyStimulus(12'h765, 1'b0, 1'b0, 1'b1, {1'b1, 4'd2}, "plain_567");
        applyStimulus(12'h321, 1'b0, 1'b0, 1'b1, {1'b0, 4'd6}, "plain_123");
        drain("plain");

        // Back-to-back accumulate: 0+6=6, then 12+6=18 gives 2 with overflow.
        applyStimulus(12'h321, 1'b1, 1'b0, 1'b1, {1'b0, 4'd6}, "acc_123");
        applyStimulus(12'h444, 1'b1, 1'b0, 1'b1, {1'b1, 4'd2}, "acc_444");
        drain("acc");

        // Clear: 0+3=3 (acc becomes 3); mode 0: 45 -> 13 with ovf; then acc is still 3.
        applyStimulus(12'h111, 1'b1, 1'b1, 1'b1, {1'b0, 4'd3}, "clear_111");
        applyStimulus(12'hFFF, 1'b0, 1'b1, 1'b1, {1'b1, 4'd13}, "plain_fff");
        applyStimulus(12'h000, 1'b1, 1'b0, 1'b1, {1'b0, 4'd3}, "accKept_000");
        drain("clear");

        // Backpressure: four beats 1..4, consumer stalls after the first result.
        fork
            begin
                applyStimulus(12'h001, 1'b0, 1'b0, 1'b1, {1'b0, 4'd1}, "bp_1");
                applyStimulus(12'h002, 1'b0, 1'b0, 1'b1, {1'b0, 4'd2}, "bp_2");
                applyStimulus(12'h003, 1'b0, 1'b0, 1'b1, {1'b0, 4'd3}, "bp_3");
                applyStimulus(12'h004, 1'b0, 1'b0, 1'b1, {1'b0, 4'd4}, "bp_4");
            end
            begin
                for (int n = 0; n < 20; n++) begin
                    @(negedge clk);
                    if (bus.out_valid) break;
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                for (int n = 0; n < 3; n++) begin
                    @(negedge clk);
                    checkOutput("bp_inReady", 32'(bus.in_ready), 32'd0);
                    checkOutput("bp_outValid", 32'(bus.out_valid), 32'd1);
                    checkOutput("bp_heldSum", 32'(bus.out_sum), 32'd2);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("bp");

        // Asynchronous reset with two beats in flight and acc=9.
        applyStimulus(12'h333, 1'b1, 1'b1, 1'b1, {1'b0, 4'd9}, "acc_333");
        drain("preRst");
        applyStimulus(12'h111, 1'b0, 1'b0, 1'b0, 5'd0, "drop_a");
        applyStimulus(12'h111, 1'b0, 1'b0, 1'b0, 5'd0, "drop_b");
        checkOutput("preRst_outValid", 32'(bus.out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("asyncRst_outValid", 32'(bus.out_valid), 32'd0);
        checkOutput("asyncRst_inReady", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(12'h002, 1'b1, 1'b0, 1'b1, {1'b0, 4'd2}, "postRst_002");
        drain("postRst");

        // Wide instance: eight 255s sum to 2040 = 248 mod 256 with overflow.
        // Also checks the two-cycle latency.
        bus8.in_data  = {64{1'b1}};
        bus8.in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("w8_lat1_outValid", 32'(bus8.out_valid), 32'd0);
        @(negedge clk);
        checkOutput("w8_lat2_outValid", 32'(bus8.out_valid), 32'd1);
        checkOutput("w8_all255", {23'd0, bus8.out_ovf, bus8.out_sum}, {23'd0, 1'b1, 8'd248});
        // Operands 1..8 sum to 36 without overflow.
        for (int k = 0; k < 8; k++) data8[k*8 +: 8] = 8'(k + 1);
        @(posedge clk);
        #1;
        bus8.in_data  = data8;
        bus8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("w8_1to8", {23'd0, bus8.out_ovf, bus8.out_sum}, {23'd0, 1'b0, 8'd36});

        // Random stream against a sum model, with random idles and backpressure.
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        modelAcc = 4'd0;
        @(posedge clk);
        #1;
        pending = 1'b0;
        sent    = 0;
        rdata   = '0;
        rmode   = 1'b0;
        rclear  = 1'b0;
        while (sent < 10000) begin
            if (!pending && ($urandom_range(0, 4) != 0)) begin
                rdata        = 12'($urandom);
                rmode        = 1'($urandom);
                rclear       = 1'($urandom);
                bus.in_data  = rdata;
                bus.in_mode  = rmode;
                bus.in_clear = rclear;
                bus.in_valid = 1'b1;
                pending      = 1'b1;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (pending && bus.in_ready) begin
                exact = int'(rdata[3:0]) + int'(rdata[7:4]) + int'(rdata[11:8]);
                if (rmode && !rclear) exact = exact + int'(modelAcc);
                expQ.push_back({(exact > 15) ? 1'b1 : 1'b0, 4'(exact)});
                tagQ.push_back("random");
                if (rmode) modelAcc = 4'(exact);
                pending = 1'b0;
                sent++;
            end
            @(posedge clk);
            #1;
            if (!pending) bus.in_valid = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
